mem_rw_sched: RTL

Read/write scheduler that shares the single memory-controller burst command port between the read side (output of the 4-channel read arbiter) and the write side (output of the write arbiter). It grants one burst at a time and bounds consecutive same-direction bursts to prevent starvation. A watchdog recovers from a burst that never completes. It sits directly between the two arbiters and the DDR controller user interface, in the mem_clk domain.

---
 rtl/mem_rw_sched.sv | 107 ++++++++++
 1 files changed

// File: rtl/mem_rw_sched.sv
// mem_rw_sched: shares one memory-controller burst command port between the read and write arbiters
//   mem_clk, rst_n                 clock, asynchronous active-low reset
//   rd_burst_req/len/addr          read burst request from the read arbiter
//   rd_burst_data_valid/data       read data returned to the read arbiter
//   rd_burst_finish                one-cycle read-complete pulse
//   wr_burst_req/len/addr          write burst request from the write arbiter
//   wr_burst_data_req/data         write data strobe out, write data in
//   wr_burst_finish                one-cycle write-complete pulse
//   mc_cmd_valid/ready/write/len/addr  burst command handshake to the controller
//   mc_rd_data_valid/data          read data from the controller
//   mc_wr_data_req/data            write data strobe from / data to the controller
//   mc_burst_done                  controller burst-complete pulse
//   timeout_err                    sticky watchdog flag, cleared only by reset
module mem_rw_sched #(
    parameter int MEM_DATA_BITS = 32,
    parameter int ADDR_BITS     = 27,
    parameter int MAX_CONSEC    = 4,
    parameter int TIMEOUT       = 8000
) (
    input  logic                     mem_clk,
    input  logic                     rst_n,
    input  logic                     rd_burst_req,
    input  logic [9:0]               rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish,
    input  logic                     wr_burst_req,
    input  logic [9:0]               wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    output logic                     mc_cmd_valid,
    output logic                     mc_cmd_write,
    output logic [9:0]               mc_cmd_len,
    output logic [ADDR_BITS-1:0]     mc_cmd_addr,
    input  logic                     mc_cmd_ready,
    input  logic                     mc_rd_data_valid,
    input  logic [MEM_DATA_BITS-1:0] mc_rd_data,
    input  logic                     mc_wr_data_req,
    output logic [MEM_DATA_BITS-1:0] mc_wr_data,
    input  logic                     mc_burst_done,
    output logic                     timeout_err
);
    typedef enum logic [2:0] {IDLE, RD_CMD, RD_XFER, RD_END, WR_CMD, WR_XFER, WR_END} state_t;
    state_t state, state_nxt;
    logic        last_dir;
    logic [3:0]  consec;
    logic [15:0] wdog;
    logic        rd_pend, wr_pend, grant, grant_wr, in_cmd, in_xfer, wdog_hit;
    assign rd_pend  = rd_burst_req && rd_burst_len != 10'd0;
    assign wr_pend  = wr_burst_req && wr_burst_len != 10'd0;
    assign grant    = state == IDLE && (rd_pend || wr_pend);
    // With both sides pending, stay on the last direction until its run reaches MAX_CONSEC.
    assign grant_wr = (rd_pend && wr_pend) ? ((consec < 4'(MAX_CONSEC)) ? last_dir : !last_dir) : wr_pend;
    assign in_cmd   = state == RD_CMD || state == WR_CMD;
    assign in_xfer  = state == RD_XFER || state == WR_XFER;
    // A done arriving on the last allowed cycle still counts as a normal completion.
    assign wdog_hit = (in_cmd || in_xfer) && wdog == 16'(TIMEOUT - 1) && !(in_xfer && mc_burst_done);
    assign rd_burst_data_valid = state == RD_XFER && mc_rd_data_valid;
    assign rd_burst_data       = state == RD_XFER ? mc_rd_data : '0;
    assign wr_burst_data_req   = state == WR_XFER && mc_wr_data_req;
    assign mc_wr_data          = wr_burst_data;
    assign rd_burst_finish     = state == RD_END;
    assign wr_burst_finish     = state == WR_END;
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:    state_nxt = grant ? (grant_wr ? WR_CMD : RD_CMD) : IDLE;
            RD_CMD:  state_nxt = wdog_hit ? RD_END : (mc_cmd_ready ? RD_XFER : RD_CMD);
            RD_XFER: state_nxt = (mc_burst_done || wdog_hit) ? RD_END : RD_XFER;
            WR_CMD:  state_nxt = wdog_hit ? WR_END : (mc_cmd_ready ? WR_XFER : WR_CMD);
            WR_XFER: state_nxt = (mc_burst_done || wdog_hit) ? WR_END : WR_XFER;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cmd_valid <= 1'b0;
            mc_cmd_write <= 1'b0;
            mc_cmd_len   <= '0;
            mc_cmd_addr  <= '0;
            last_dir     <= 1'b0;
            consec       <= '0;
            wdog         <= '0;
            timeout_err  <= 1'b0;
        end else begin
            wdog <= (in_cmd || in_xfer) ? wdog + 16'd1 : 16'd0;
            if (wdog_hit) timeout_err <= 1'b1;
            if (grant) begin
                mc_cmd_valid <= 1'b1;
                mc_cmd_write <= grant_wr;
                mc_cmd_len   <= grant_wr ? wr_burst_len : rd_burst_len;
                mc_cmd_addr  <= grant_wr ? wr_burst_addr : rd_burst_addr;
                consec       <= (grant_wr == last_dir) ? ((consec == 4'd15) ? consec : consec + 4'd1) : 4'd1;
                last_dir     <= grant_wr;
            end else if (in_cmd && (mc_cmd_ready || wdog_hit)) begin
                mc_cmd_valid <= 1'b0;
            end
        end
    end
endmodule
